// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: controller state encoding and default depth.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_fifo_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the register-side push port, the transmitter handshake and the FIFO status.
interface uart_tx_fifo_if import uart_pkg::*; #(parameter int DEPTH = UART_FIFO_DEPTH);

    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wdata;
    logic          clr_ovf;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    modport master (
        output wr_en, wdata, clr_ovf, tx_busy, tx_done,
        input  tx_start, tx_data, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wdata, clr_ovf, tx_busy, tx_done,
        output tx_start, tx_data, full, empty, count, overflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 circular buffer with wrapping pointers and an occupancy counter.
module sync_fifo_mem import uart_pkg::*; #(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop on the same edge frees a slot, so a push into a full buffer still lands.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter: buffers pushed bytes and launches one frame at a time.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no frame in flight; pops as soon as data and tx_busy=0
// LAUNCH    | tx_start high for this single cycle
// WAIT_BUSY | waiting for the transmitter to pick up the frame
// WAIT_DONE | frame in progress, waiting for tx_done
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
    end

    tx_fifo_state_e state;
    logic           pop;
    logic           drop;
    logic [7:0]     rdata;

    assign pop  = (state == IDLE) && !bus.empty && !bus.tx_busy;
    assign drop = bus.wr_en && bus.full && !pop;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_en),
        .pop   (pop),
        .wdata (bus.wdata),
        .rdata (rdata),
        .count (bus.count),
        .full  (bus.full),
        .empty (bus.empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.overflow <= 1'b0;
        end else begin
            // A dropped push outranks a clear arriving on the same edge.
            if (drop) begin
                bus.overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                bus.overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.tx_data  <= rdata;
                        bus.tx_start <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.tx_start <= 1'b0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end else if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus a simple transmitter model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [7:0] q [$];
    logic       m_ovf;
    logic       m_start;
    logic [7:0] m_data;
    logic       m_engaged;
    logic       m_launch;

    // transmitter model state
    int         tx_cnt;
    int         frame_len;
    logic       hold_busy;

    // observed launches
    logic [7:0] seq [$];
    int         starts;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Applies the FIFO rules to the model for the edge just taken.
    task automatic model_edge();
        bit do_pop;
        bit full_pre;
        bit do_drop;
        if (reset) begin
            q.delete();
            m_ovf     = 1'b0;
            m_start   = 1'b0;
            m_data    = 8'h00;
            m_engaged = 1'b0;
            m_launch  = 1'b0;
            return;
        end
        full_pre = (q.size() == DEPTH);
        do_pop   = !m_engaged && (q.size() != 0) && !bus.tx_busy;
        do_drop  = bus.wr_en && full_pre && !do_pop;
        if (do_pop) m_data = q.pop_front();
        if (bus.wr_en && !do_drop) q.push_back(bus.wdata);
        if (do_drop) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
        if (do_pop) begin
            m_engaged = 1'b1;
            m_launch  = 1'b1;
        end else if (m_launch) begin
            m_launch = 1'b0;
        end else if (m_engaged && bus.tx_done) begin
            m_engaged = 1'b0;
        end
        m_start = do_pop;
    endtask

    // Transmitter: busy for frame_len cycles after a start, then a done pulse.
    task automatic tx_env();
        logic done_n;
        done_n = 1'b0;
        if (reset) begin
            tx_cnt = 0;
        end else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                done_n = (tx_cnt == 0);
            end
            if (m_start) tx_cnt = frame_len + 1;
        end
        bus.tx_busy = hold_busy || (tx_cnt > 0 && !done_n && !m_start) || (m_start && 1'b0);
        bus.tx_done = done_n;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("count",    32'(bus.count),    32'(q.size()));
        chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(q.size() == 0));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("tx_start", 32'(bus.tx_start), 32'(m_start));
        chk("tx_data",  32'(bus.tx_data),  32'(m_data));
        if (bus.tx_start === 1'b1) begin
            seq.push_back(bus.tx_data);
            starts++;
        end
        tx_env();
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wr_en = 1'b1;
        bus.wdata = b;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_engaged || q.size() != 0 || tx_cnt != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'(q.size() + int'(m_engaged)), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wdata   = 8'h00;
        bus.clr_ovf = 1'b0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        hold_busy   = 1'b0;
        tx_cnt      = 0;
        frame_len   = 3;
        starts      = 0;
        q.delete();
        m_ovf = 0; m_start = 0; m_data = 0; m_engaged = 0; m_launch = 0;

        repeat (3) step();
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        step();

        // single byte latency
        push_byte(8'h55);
        chk("lat_k",      32'(bus.tx_start), 32'd0);
        step();
        chk("lat_k1",     32'(bus.tx_start), 32'd1);
        chk("lat_data",   32'(bus.tx_data),  32'h55);
        step();
        chk("lat_k2",     32'(bus.tx_start), 32'd0);
        chk("lat_hold",   32'(bus.tx_data),  32'h55);
        wait_idle(200);

        // fill, overflow, clear, simultaneous push/pop at full, then drain in order
        seq.delete();
        frame_len   = 10;
        hold_busy   = 1'b1;
        bus.tx_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        bus.clr_ovf = 1'b1;
        push_byte(8'hAA);
        bus.clr_ovf = 1'b0;
        chk("ovf_set",    32'(bus.overflow), 32'd1);
        chk("ovf_count",  32'(bus.count),    32'd16);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        chk("ovf_clr",    32'(bus.overflow), 32'd0);
        hold_busy   = 1'b0;
        bus.tx_busy = 1'b0;
        push_byte(8'h11);
        chk("pp_count",   32'(bus.count), 32'd16);
        chk("pp_full",    32'(bus.full),  32'd1);
        wait_idle(600);
        chk("order_len",  32'(seq.size()), 32'd17);
        for (int i = 0; i < 17 && i < seq.size(); i++) chk("order_byte", 32'(seq[i]), 32'(i + 1));

        // transmitter held busy: nothing launches until release
        hold_busy   = 1'b1;
        bus.tx_busy = 1'b1;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        starts = 0;
        repeat (5) step();
        chk("hold_count", 32'(bus.count), 32'd3);
        chk("hold_start", 32'(starts),    32'd0);
        frame_len   = 5;
        hold_busy   = 1'b0;
        bus.tx_busy = 1'b0;
        starts = 0;
        repeat (4) step();
        chk("release_one_start", 32'(starts), 32'd1);
        wait_idle(300);

        // reset while a frame is in progress
        frame_len = 20;
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
        repeat (3) step();
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_count", 32'(bus.count),    32'd0);
        chk("mid_rst_empty", 32'(bus.empty),    32'd1);
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        starts = 0;
        repeat (30) step();
        chk("post_rst_starts", 32'(starts), 32'd0);
        frame_len = 2;
        push_byte(8'h77);
        step();
        chk("post_rst_launch", 32'(bus.tx_start), 32'd1);
        chk("post_rst_data",   32'(bus.tx_data),  32'h77);
        wait_idle(100);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 40);
            bus.wdata   = 8'($urandom);
            bus.clr_ovf = ($urandom_range(0, 99) < 5);
            reset       = ($urandom_range(0, 499) == 0);
            frame_len   = $urandom_range(1, 6);
            if ($urandom_range(0, 99) < 3) hold_busy = ~hold_busy;
            step();
        end
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        reset       = 1'b0;
        hold_busy   = 1'b0;
        wait_idle(800);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default $clog2(DEPTH), pointer width; derived, never overridden.
REQ-003 Port clk  input  1  sole clock; all state SHALL change on posedge clk only.
REQ-004 Port reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 Port wr_en  input  1  push request from the APB register side, one byte per cycle.
REQ-006 Port wdata  input  8  byte to push.
REQ-007 Port clr_ovf  input  1  clears the overflow flag.
REQ-008 Port tx_busy  input  1  transmitter busy, from the UART transmitter.
REQ-009 Port tx_done  input  1  one-cycle end-of-frame pulse from the UART transmitter.
REQ-010 Port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 Port tx_data  output  8  byte presented to the UART transmitter.
REQ-012 Port full  output  1  count == DEPTH.
REQ-013 Port empty  output  1  count == 0.
REQ-014 Port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-015 Port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-016 Storage SHALL be a DEPTH x 8 circular buffer with AW-bit write and read pointers that wrap modulo DEPTH.
REQ-017 A push with wr_en=1 and full=0 SHALL write wdata at wptr, advance wptr and increment count at that edge.
REQ-018 A push with wr_en=1 and full=1 SHALL be dropped, leave the buffer unchanged and set overflow at that edge.
REQ-019 clr_ovf=1 SHALL clear overflow at the next edge; a simultaneous drop SHALL win, leaving overflow=1.
REQ-020 The control FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: when empty=0 and tx_busy=0, the next edge SHALL pop (tx_data<=mem[rptr], advance rptr, decrement count), set tx_start=1 and enter LAUNCH.
REQ-022 LAUNCH: the next edge SHALL clear tx_start and enter WAIT_BUSY, so tx_start is high for exactly one cycle.
REQ-023 WAIT_BUSY: tx_busy=1 SHALL enter WAIT_DONE; tx_done=1 SHALL enter IDLE directly.
REQ-024 WAIT_DONE: tx_done=1 SHALL enter IDLE; otherwise the FSM SHALL stay in WAIT_DONE.
REQ-025 tx_data SHALL remain stable from the pop edge until the next pop.
REQ-026 Latency: a push into an empty FIFO at edge k with tx_busy=0 SHALL give tx_start=1 during cycle k+1..k+2, i.e. after edge k+1.
REQ-027 A simultaneous push and pop SHALL leave count unchanged, and both operations SHALL take effect, including when full=1 at that edge.
REQ-028 A push into an empty FIFO SHALL NOT bypass to tx_data; every byte passes through storage.
REQ-029 full, empty and count SHALL be registered-state derived (combinational from count), with no dependence on wr_en.
REQ-030 Bytes SHALL be transmitted in push order, with no loss and no duplication, for any pattern that never overflows.

Reset
REQ-031 reset=1 SHALL force the FSM to IDLE, wptr=rptr=0, count=0, tx_start=0, tx_data=0 and overflow=0 at the next edge, including mid-frame.
REQ-032 Buffer memory SHALL NOT be reset; reset SHALL override wr_en and clr_ovf.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum (tx_fifo_state_e) and the default DEPTH constant.
REQ-034 A single sub-module, sync_fifo_mem (DEPTH x 8 storage with pointers and count), is natural; the FSM SHALL live in uart_tx_fifo.

Verification
REQ-035 Reset, then push 0x55 with tx_busy=0 -> tx_start pulses for one cycle after edge k+1 and tx_data=0x55.
REQ-036 Push 0x01..0x10 back-to-back, with the transmitter model at busy 10 cycles per byte -> full=1 after the 16th push, and all 16 bytes emerge in order.
REQ-037 With the FIFO full, push 0xAA -> it is dropped, overflow=1 and count=16; then pulse clr_ovf -> overflow=0.
REQ-038 Hold tx_busy=1 with count=3 -> no tx_start; release tx_busy -> exactly one tx_start, then wait for tx_done.
REQ-039 Push and pop on the same edge with count=16 -> count stays 16 and full stays 1.
REQ-040 Assert reset in WAIT_DONE with count=5 -> count=0, empty=1, tx_start=0 and FSM=IDLE after one edge, with no tx_start afterwards.
